// File: rtl/slc_cfg_pkg.sv
// Package for the super-logic-cell configuration loader.
// Holds the loader state encoding, the frame layout (payload byte offsets),
// default header/timeout values and a payload checksum helper.
// Optional build macro used by the loader: SLC_CFG_READBACK_EN.
package slc_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2
  } cfg_state_t;

  localparam int PAYLOAD_BYTES = 20;
  localparam int PAYLOAD_W     = PAYLOAD_BYTES * 8;

  // Byte offsets of each field inside the payload
  localparam int LUT_OFS  = 0;
  localparam int MODE_OFS = 16;
  localparam int QDI_OFS  = 17;
  localparam int BQZ_OFS  = 18;
  localparam int CQZ_OFS  = 19;

  localparam logic [7:0] DEFAULT_HDR     = 8'hA5;
  localparam int         DEFAULT_TIMEOUT = 16;

  // XOR of all payload bytes, i.e. the frame checksum byte
  function automatic logic [7:0] payload_xor(input logic [PAYLOAD_W-1:0] payload);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      acc = acc ^ payload[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/slc_cfg_readback.sv
// Byte serializer of the active SLC configuration.
// On start it streams payload bytes P0..P19 followed by their XOR checksum
// (21 bytes) over a valid/ready handshake. Each byte is held until accepted.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a readback (ignored while busy)
//   payload    : active configuration, byte b at payload[8b+7:8b]
//   rb_rdy     : downstream ready
//   rb_do      : output byte
//   rb_vld     : output byte valid
//   busy       : readback in progress
module slc_cfg_readback
  import slc_cfg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic                 rb_rdy,
  output logic [7:0]           rb_do,
  output logic                 rb_vld,
  output logic                 busy
);

  localparam logic [4:0] LAST_IDX = 5'(PAYLOAD_BYTES);  // checksum position

  logic [4:0] rb_idx_reg;
  logic       rb_vld_reg;
  logic [7:0] rb_do_reg;

  // Index PAYLOAD_BYTES selects the checksum. The payload cannot change while
  // a readback runs because the loader refuses bytes, so it is read live.
  function automatic logic [7:0] byte_at(input logic [4:0] idx);
    if (idx < 5'(PAYLOAD_BYTES)) return payload[idx*8 +: 8];
    return payload_xor(payload);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_idx_reg <= '0;
      rb_vld_reg <= 1'b0;
      rb_do_reg  <= '0;
    end else if (!rb_vld_reg) begin
      if (start) begin
        rb_idx_reg <= '0;
        rb_vld_reg <= 1'b1;
        rb_do_reg  <= byte_at(5'd0);
      end
    end else if (rb_rdy) begin
      if (rb_idx_reg == LAST_IDX) begin
        rb_vld_reg <= 1'b0;
      end else begin
        rb_idx_reg <= 5'(rb_idx_reg + 5'd1);
        rb_do_reg  <= byte_at(5'(rb_idx_reg + 5'd1));
      end
    end
  end

  assign rb_do  = rb_do_reg;
  assign rb_vld = rb_vld_reg;
  assign busy   = rb_vld_reg;

endmodule

// File: rtl/slc_cfg_loader.sv
// Writer side of the super-logic-cell configuration interface.
// Accepts a byte frame {HDR_BYTE, P0..P19, XOR(P0..P19)} over valid/ready,
// fills a shadow copy, and on a matching checksum copies it to the active
// outputs in one edge. Bad checksum or an idle gap of TIMEOUT cycles inside
// a frame sets the sticky CFG_ERR; it clears when the next header is accepted.
// Optional macro SLC_CFG_READBACK_EN adds a readback port (RB_*) that streams
// the active configuration back out; CFG_RDY drops while it runs.
// Ports:
//   QCK, QRT_N      : clock, asynchronous active-low reset
//   CFG_DI/VLD/RDY  : config byte stream
//   LUT_CFG         : LUT tables, LC k at [16k+15:16k]
//   LC_MODE, LC_QDI_MUX, LC_BQZ_MUX, LC_CQZ_MUX : per-LC mode/mux bits
//   CFG_BUSY        : frame in progress
//   CFG_DONE        : one-cycle pulse after a good commit
//   CFG_ERR         : sticky error
//   RB_REQ/DO/VLD/RDY (SLC_CFG_READBACK_EN only) : readback stream
module slc_cfg_loader
  import slc_cfg_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE = DEFAULT_HDR,
  parameter int         TIMEOUT  = DEFAULT_TIMEOUT   // legal 2..255
) (
  input  logic         QCK,
  input  logic         QRT_N,
  input  logic [7:0]   CFG_DI,
  input  logic         CFG_VLD,
  output logic         CFG_RDY,
  output logic [127:0] LUT_CFG,
  output logic [7:0]   LC_MODE,
  output logic [7:0]   LC_QDI_MUX,
  output logic [7:0]   LC_BQZ_MUX,
  output logic [7:0]   LC_CQZ_MUX,
`ifdef SLC_CFG_READBACK_EN
  input  logic         RB_REQ,
  output logic [7:0]   RB_DO,
  output logic         RB_VLD,
  input  logic         RB_RDY,
`endif
  output logic         CFG_BUSY,
  output logic         CFG_DONE,
  output logic         CFG_ERR
);

  localparam logic [4:0] LAST_IDX = 5'(PAYLOAD_BYTES - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  cfg_state_t           state_reg, state_next;
  logic [4:0]           idx_reg, idx_next;
  logic [7:0]           xor_reg, xor_next;
  logic [7:0]           idle_cnt_reg, idle_cnt_next;
  logic                 err_reg, err_next;
  logic                 done_reg, done_next;
  logic [PAYLOAD_W-1:0] shadow;
  logic [PAYLOAD_W-1:0] active_reg;
  logic                 cfg_rdy, xfer, shadow_we, commit;

  assign xfer = CFG_VLD && cfg_rdy;

  always_ff @(posedge QCK or negedge QRT_N) begin
    if (!QRT_N) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      xor_reg      <= '0;
      idle_cnt_reg <= '0;
      err_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      xor_reg      <= xor_next;
      idle_cnt_reg <= idle_cnt_next;
      err_reg      <= err_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    xor_next      = xor_reg;
    idle_cnt_next = idle_cnt_reg;
    err_next      = err_reg;
    done_next     = 1'b0;
    shadow_we     = 1'b0;
    commit        = 1'b0;
    case (state_reg)
      IDLE: begin
        // Non-header bytes are accepted and dropped here
        if (xfer && CFG_DI == HDR_BYTE) begin
          state_next    = LOAD;
          idx_next      = '0;
          xor_next      = '0;
          idle_cnt_next = '0;
          err_next      = 1'b0;
        end
      end
      LOAD, CHK: begin
        if (xfer) begin
          idle_cnt_next = '0;
          if (state_reg == LOAD) begin
            shadow_we = 1'b1;
            xor_next  = xor_reg ^ CFG_DI;
            if (idx_reg == LAST_IDX) state_next = CHK;
            else                     idx_next   = 5'(idx_reg + 5'd1);
          end else begin
            state_next = IDLE;
            if (CFG_DI == xor_reg) begin
              commit    = 1'b1;
              done_next = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end
        end else if (idle_cnt_reg == TMO_LAST) begin
          // This idle cycle is the TIMEOUT-th in a row: abandon the frame
          state_next    = IDLE;
          err_next      = 1'b1;
          idle_cnt_next = '0;
        end else begin
          idle_cnt_next = 8'(idle_cnt_reg + 8'd1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow storage, one byte register per payload position
  genvar gi;
  generate
    for (gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_shadow
      logic [7:0] byte_reg;
      always_ff @(posedge QCK or negedge QRT_N) begin
        if (!QRT_N)                                  byte_reg <= '0;
        else if (shadow_we && idx_reg == 5'(gi))     byte_reg <= CFG_DI;
      end
      assign shadow[gi*8 +: 8] = byte_reg;
    end
  endgenerate

  // Whole-word copy keeps the active configuration atomic
  always_ff @(posedge QCK or negedge QRT_N) begin
    if (!QRT_N)      active_reg <= '0;
    else if (commit) active_reg <= shadow;
  end

`ifdef SLC_CFG_READBACK_EN
  logic rb_busy, rb_start;
  // Holding CFG_RDY low in the request cycle stops a header sneaking in
  // on the same edge the readback starts.
  assign rb_start = RB_REQ && !rb_busy && state_reg == IDLE;
  assign cfg_rdy  = !(rb_busy || rb_start);

  slc_cfg_readback u_readback (
    .clk     (QCK),
    .rst_n   (QRT_N),
    .start   (rb_start),
    .payload (active_reg),
    .rb_rdy  (RB_RDY),
    .rb_do   (RB_DO),
    .rb_vld  (RB_VLD),
    .busy    (rb_busy)
  );
`else
  assign cfg_rdy = 1'b1;
`endif

  assign CFG_RDY    = cfg_rdy;
  assign LUT_CFG    = active_reg[LUT_OFS*8 +: 128];
  assign LC_MODE    = active_reg[MODE_OFS*8 +: 8];
  assign LC_QDI_MUX = active_reg[QDI_OFS*8 +: 8];
  assign LC_BQZ_MUX = active_reg[BQZ_OFS*8 +: 8];
  assign LC_CQZ_MUX = active_reg[CQZ_OFS*8 +: 8];
  assign CFG_BUSY   = state_reg != IDLE;
  assign CFG_DONE   = done_reg;
  assign CFG_ERR    = err_reg;

endmodule

// File: tb/tb_slc_cfg_loader.sv
// Self-checking bench for slc_cfg_loader: directed frames plus randomized
// frames, checked against a byte-level model of the frame format.
module tb_slc_cfg_loader;

  localparam int TMO = 16;

  logic         QCK = 1'b0;
  logic         QRT_N = 1'b0;
  logic [7:0]   CFG_DI = 8'h00;
  logic         CFG_VLD = 1'b0;
  logic         CFG_RDY;
  logic [127:0] LUT_CFG;
  logic [7:0]   LC_MODE, LC_QDI_MUX, LC_BQZ_MUX, LC_CQZ_MUX;
  logic         CFG_BUSY, CFG_DONE, CFG_ERR;
`ifdef SLC_CFG_READBACK_EN
  logic         RB_REQ = 1'b0;
  logic         RB_RDY = 1'b0;
  logic [7:0]   RB_DO;
  logic         RB_VLD;
`endif

  slc_cfg_loader #(.HDR_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
    .QCK        (QCK),
    .QRT_N      (QRT_N),
    .CFG_DI     (CFG_DI),
    .CFG_VLD    (CFG_VLD),
    .CFG_RDY    (CFG_RDY),
    .LUT_CFG    (LUT_CFG),
    .LC_MODE    (LC_MODE),
    .LC_QDI_MUX (LC_QDI_MUX),
    .LC_BQZ_MUX (LC_BQZ_MUX),
    .LC_CQZ_MUX (LC_CQZ_MUX),
`ifdef SLC_CFG_READBACK_EN
    .RB_REQ     (RB_REQ),
    .RB_DO      (RB_DO),
    .RB_VLD     (RB_VLD),
    .RB_RDY     (RB_RDY),
`endif
    .CFG_BUSY   (CFG_BUSY),
    .CFG_DONE   (CFG_DONE),
    .CFG_ERR    (CFG_ERR)
  );

  always #5 QCK = ~QCK;

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;

  // Reference model: current payload being sent and expected active config
  logic [7:0]   p [20];
  logic [127:0] exp_lut = '0;
  logic [7:0]   exp_mode = '0, exp_qdi = '0, exp_bqz = '0, exp_cqz = '0;

  function automatic logic [7:0] ref_csum();
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 20; i++) c = c ^ p[i];
    return c;
  endfunction

  function automatic void model_commit();
    for (int k = 0; k < 8; k++) exp_lut[16*k +: 16] = {p[2*k+1], p[2*k]};
    exp_mode = p[16];
    exp_qdi  = p[17];
    exp_bqz  = p[18];
    exp_cqz  = p[19];
  endfunction

  function automatic void model_clear();
    exp_lut = '0; exp_mode = '0; exp_qdi = '0; exp_bqz = '0; exp_cqz = '0;
  endfunction

  function automatic logic [159:0] dut_cfg();
    return {LUT_CFG, LC_MODE, LC_QDI_MUX, LC_BQZ_MUX, LC_CQZ_MUX};
  endfunction

  function automatic logic [159:0] exp_cfg();
    return {exp_lut, exp_mode, exp_qdi, exp_bqz, exp_cqz};
  endfunction

  // Stimulus helpers (no checking inside)
  task automatic tick();
    @(posedge QCK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    CFG_DI  = b;
    CFG_VLD = 1'b1;
    tick();
  endtask

  task automatic stall(input int n);
    CFG_VLD = 1'b0;
    repeat (n) tick();
  endtask

  task automatic random_payload();
    for (int i = 0; i < 20; i++) p[i] = 8'($urandom);
  endtask

  task automatic send_body(input logic [7:0] flip);
    for (int i = 0; i < 20; i++) send(p[i]);
    send(ref_csum() ^ flip);
    CFG_VLD = 1'b0;
    n_frames++;
    $display("frame %0d: csum %02h flip %02h", n_frames, ref_csum(), flip);
  endtask

  task automatic test_reset();
    QRT_N = 1'b0;
    tick();
    tick();
    n_checks++;
    if (dut_cfg() !== 160'h0) begin
      n_fail++; $display("FAIL reset_cfg: got %h want 0", dut_cfg());
    end
    n_checks++;
    if ({CFG_RDY, CFG_BUSY, CFG_DONE, CFG_ERR} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags: got rdy/busy/done/err %b want 1000",
                         {CFG_RDY, CFG_BUSY, CFG_DONE, CFG_ERR});
    end
`ifdef SLC_CFG_READBACK_EN
    n_checks++;
    if ({RB_VLD, RB_DO} !== 9'h0) begin
      n_fail++; $display("FAIL reset_rb: got vld %b do %h want 0", RB_VLD, RB_DO);
    end
`endif
    QRT_N = 1'b1;
    tick();
  endtask

  task automatic load_case1();
    logic [15:0] luts [8];
    luts = '{16'hBEEF, 16'hCAFE, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h4242, 16'h0123};
    for (int k = 0; k < 8; k++) begin
      p[2*k]   = luts[k][7:0];
      p[2*k+1] = luts[k][15:8];
    end
    p[16] = 8'h0F; p[17] = 8'h33; p[18] = 8'h55; p[19] = 8'hAA;
  endtask

  task automatic test_good_frame();
    load_case1();
    send(8'hA5);
    n_checks++;
    if (CFG_BUSY !== 1'b1) begin
      n_fail++; $display("FAIL good_busy: got %b want 1", CFG_BUSY);
    end
    send_body(8'h00);
    model_commit();
    n_checks++;
    if (dut_cfg() !== exp_cfg()) begin
      n_fail++; $display("FAIL good_cfg: got %h want %h", dut_cfg(), exp_cfg());
    end
    n_checks++;
    if ({CFG_DONE, CFG_ERR} !== 2'b10) begin
      n_fail++; $display("FAIL good_done: got done/err %b want 10", {CFG_DONE, CFG_ERR});
    end
    tick();
    n_checks++;
    if ({CFG_DONE, CFG_BUSY} !== 2'b00) begin
      n_fail++; $display("FAIL good_pulse: got done/busy %b want 00", {CFG_DONE, CFG_BUSY});
    end
  endtask

  task automatic test_bad_checksum();
    random_payload();
    send(8'hA5);
    send_body(8'h01);
    n_checks++;
    if ({CFG_ERR, CFG_DONE, CFG_BUSY} !== 3'b100) begin
      n_fail++; $display("FAIL bad_err: got err/done/busy %b want 100", {CFG_ERR, CFG_DONE, CFG_BUSY});
    end
    n_checks++;
    if (dut_cfg() !== exp_cfg()) begin
      n_fail++; $display("FAIL bad_keep: got %h want %h", dut_cfg(), exp_cfg());
    end
    tick();
    n_checks++;
    if ({CFG_ERR, CFG_DONE} !== 2'b10) begin
      n_fail++; $display("FAIL bad_sticky: got err/done %b want 10", {CFG_ERR, CFG_DONE});
    end
    random_payload();
    send(8'hA5);
    n_checks++;
    if (CFG_ERR !== 1'b0) begin
      n_fail++; $display("FAIL bad_clear: got err %b want 0", CFG_ERR);
    end
    send_body(8'h00);
    model_commit();
    n_checks++;
    if (dut_cfg() !== exp_cfg() || CFG_DONE !== 1'b1) begin
      n_fail++; $display("FAIL bad_recover: got %h done %b want %h done 1", dut_cfg(), CFG_DONE, exp_cfg());
    end
  endtask

  task automatic test_timeout();
    random_payload();
    send(8'hA5);
    for (int i = 0; i < 8; i++) send(p[i]);
    stall(TMO - 1);
    n_checks++;
    if ({CFG_BUSY, CFG_ERR} !== 2'b10) begin
      n_fail++; $display("FAIL tmo_early: got busy/err %b want 10", {CFG_BUSY, CFG_ERR});
    end
    stall(1);
    n_checks++;
    if ({CFG_BUSY, CFG_ERR} !== 2'b01) begin
      n_fail++; $display("FAIL tmo_fire: got busy/err %b want 01", {CFG_BUSY, CFG_ERR});
    end
    n_checks++;
    if (dut_cfg() !== exp_cfg()) begin
      n_fail++; $display("FAIL tmo_keep: got %h want %h", dut_cfg(), exp_cfg());
    end
    $display("frame timeout after P7: busy %b err %b", CFG_BUSY, CFG_ERR);
    // Longest legal stall, then finish the frame
    random_payload();
    send(8'hA5);
    for (int i = 0; i < 8; i++) send(p[i]);
    stall(TMO - 1);
    for (int i = 8; i < 20; i++) send(p[i]);
    send(ref_csum());
    CFG_VLD = 1'b0;
    model_commit();
    n_checks++;
    if (dut_cfg() !== exp_cfg() || {CFG_DONE, CFG_ERR} !== 2'b10) begin
      n_fail++; $display("FAIL tmo_resume: got %h done/err %b want %h 10", dut_cfg(), {CFG_DONE, CFG_ERR}, exp_cfg());
    end
  endtask

  task automatic test_back_to_back();
    send(8'h00);
    send(8'hFF);
    n_checks++;
    if (CFG_BUSY !== 1'b0) begin
      n_fail++; $display("FAIL garbage_busy: got %b want 0", CFG_BUSY);
    end
    random_payload();
    p[3]  = 8'hA5;
    p[12] = 8'hA5;
    send(8'hA5);
    send_body(8'h00);
    model_commit();
    n_checks++;
    if (dut_cfg() !== exp_cfg() || CFG_DONE !== 1'b1) begin
      n_fail++; $display("FAIL hdr_in_data: got %h done %b want %h done 1", dut_cfg(), CFG_DONE, exp_cfg());
    end
    random_payload();
    send(8'hA5);
    n_checks++;
    if ({CFG_BUSY, CFG_DONE} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_hdr: got busy/done %b want 10", {CFG_BUSY, CFG_DONE});
    end
    send_body(8'h00);
    model_commit();
    n_checks++;
    if (dut_cfg() !== exp_cfg() || CFG_DONE !== 1'b1) begin
      n_fail++; $display("FAIL b2b_commit: got %h done %b want %h done 1", dut_cfg(), CFG_DONE, exp_cfg());
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 24; f++) begin
      logic [7:0] flip;
      random_payload();
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      stall($urandom_range(0, 3));
      send(8'hA5);
      for (int i = 0; i < 21; i++) begin
        if ($urandom_range(0, 3) == 0) stall($urandom_range(1, TMO - 1));
        send(i < 20 ? p[i] : (ref_csum() ^ flip));
      end
      CFG_VLD = 1'b0;
      if (flip == 8'h00) model_commit();
      $display("frame rand %0d: flip %02h done %b err %b", f, flip, CFG_DONE, CFG_ERR);
      n_checks++;
      if (dut_cfg() !== exp_cfg()) begin
        n_fail++; $display("FAIL rand_cfg[%0d]: got %h want %h", f, dut_cfg(), exp_cfg());
      end
      n_checks++;
      if ({CFG_DONE, CFG_ERR} !== ((flip == 8'h00) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rand_flags[%0d]: got done/err %b want %b", f, {CFG_DONE, CFG_ERR},
                           (flip == 8'h00) ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    random_payload();
    send(8'hA5);
    for (int i = 0; i < 10; i++) send(p[i]);
    CFG_DI  = p[10];
    CFG_VLD = 1'b1;
    #1 QRT_N = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if (dut_cfg() !== exp_cfg() || {CFG_BUSY, CFG_DONE, CFG_ERR} !== 3'b000) begin
      n_fail++; $display("FAIL midreset: got %h busy/done/err %b want 0 000", dut_cfg(),
                         {CFG_BUSY, CFG_DONE, CFG_ERR});
    end
    tick();
    CFG_VLD = 1'b0;
    QRT_N   = 1'b1;
    tick();
    random_payload();
    send(8'hA5);
    send_body(8'h00);
    model_commit();
    n_checks++;
    if (dut_cfg() !== exp_cfg() || CFG_DONE !== 1'b1) begin
      n_fail++; $display("FAIL midreset_recover: got %h done %b want %h done 1", dut_cfg(), CFG_DONE, exp_cfg());
    end
  endtask

`ifdef SLC_CFG_READBACK_EN
  task automatic test_readback();
    logic [7:0] got_q [$];
    int rdy_bad;
    load_case1();
    send(8'hA5);
    send_body(8'h00);
    model_commit();
    tick();
    RB_REQ = 1'b1;
    rdy_bad = 0;
    if (CFG_RDY !== 1'b0) rdy_bad++;
    tick();
    RB_REQ = 1'b0;
    for (int cyc = 0; cyc < 400 && got_q.size() < 21; cyc++) begin
      RB_RDY = 1'($urandom_range(0, 1));
      if (CFG_RDY !== 1'b0) rdy_bad++;
      if (RB_VLD === 1'b1 && RB_RDY) begin
        got_q.push_back(RB_DO);
        $display("readback byte %0d: %02h", got_q.size() - 1, RB_DO);
      end
      tick();
    end
    RB_RDY = 1'b0;
    n_checks++;
    if (got_q.size() != 21) begin
      n_fail++; $display("FAIL rb_count: got %0d bytes want 21", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 21; i++) begin
      n_checks++;
      if (got_q[i] !== ((i < 20) ? p[i] : ref_csum())) begin
        n_fail++; $display("FAIL rb_byte[%0d]: got %02h want %02h", i, got_q[i],
                           (i < 20) ? p[i] : ref_csum());
      end
    end
    n_checks++;
    if (rdy_bad != 0) begin
      n_fail++; $display("FAIL rb_cfg_rdy: got %0d cycles with CFG_RDY high want 0", rdy_bad);
    end
    n_checks++;
    if ({RB_VLD, CFG_RDY} !== 2'b01 || dut_cfg() !== exp_cfg()) begin
      n_fail++; $display("FAIL rb_end: got vld/rdy %b cfg %h want 01 %h", {RB_VLD, CFG_RDY}, dut_cfg(), exp_cfg());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_timeout();
    test_back_to_back();
    test_random_frames();
    test_reset_mid_frame();
`ifdef SLC_CFG_READBACK_EN
    test_readback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
